// File: rtl/div_sqrt_issue_ctrl.sv
// Issue/response controller for an iterative div/sqrt unit, one operation outstanding at a time.
// Optional macro DIV_SQRT_RESP_FIFO_EN swaps the single response register for a 2-entry response FIFO.
module div_sqrt_issue_ctrl #(
    parameter int TAG_W    = 4,
    parameter int DATA_W   = 32,
    parameter int C_DIV_RM = 3,
    parameter int C_DIV_PC = 6
) (
    input  logic                Clk_CI,
    input  logic                Rst_RBI,
    input  logic                In_valid_SI,
    output logic                In_ready_SO,
    input  logic                Sqrt_sel_SI,
    input  logic [DATA_W-1:0]   Operand_a_DI,
    input  logic [DATA_W-1:0]   Operand_b_DI,
    input  logic [C_DIV_RM-1:0] RM_SI,
    input  logic [C_DIV_PC-1:0] Precision_ctl_SI,
    input  logic [TAG_W-1:0]    Tag_DI,
    output logic                Div_start_SO,
    output logic                Sqrt_start_SO,
    output logic [DATA_W-1:0]   Operand_a_DO,
    output logic [DATA_W-1:0]   Operand_b_DO,
    output logic [C_DIV_RM-1:0] RM_SO,
    output logic [C_DIV_PC-1:0] Precision_ctl_SO,
    input  logic [DATA_W-1:0]   Result_DI,
    input  logic                Exp_OF_SI,
    input  logic                Exp_UF_SI,
    input  logic                Div_zero_SI,
    input  logic                Ready_SI,
    input  logic                Done_SI,
    output logic                Out_valid_SO,
    input  logic                Out_ready_SI,
    output logic [DATA_W-1:0]   Result_DO,
    output logic [2:0]          Flags_DO,
    output logic [TAG_W-1:0]    Tag_DO,
    output logic                Err_spurious_SO
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, BUSY = 2'd2, RESP = 2'd3} state_t;

    localparam int ENTRY_W = DATA_W + 3 + TAG_W;

`ifdef DIV_SQRT_RESP_FIFO_EN
    localparam state_t DONE_STATE = IDLE;
`else
    localparam state_t DONE_STATE = RESP;
`endif

    state_t               state_r, state_s;
    logic [DATA_W-1:0]    op_a_r, op_b_r;
    logic [C_DIV_RM-1:0]  rm_r;
    logic [C_DIV_PC-1:0]  pc_r;
    logic                 sqrt_r;
    logic [TAG_W-1:0]     tag_r;
    logic                 err_spurious_r;
    logic                 accept_s, start_s, push_s, pop_s, buf_free_s, buf_valid_s;
    logic [ENTRY_W-1:0]   push_entry_s, head_entry_s;

    assign In_ready_SO  = (state_r == IDLE) && buf_free_s;
    assign accept_s     = In_valid_SI && In_ready_SO;
    assign start_s      = (state_r == ISSUE) && Ready_SI;
    assign push_s       = (state_r == BUSY) && Done_SI;
    assign pop_s        = buf_valid_s && Out_ready_SI;
    assign push_entry_s = {Result_DI, Div_zero_SI, Exp_OF_SI, Exp_UF_SI, tag_r};

    // State register
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_s = ISSUE;
                else          state_s = IDLE;
            end
            ISSUE: begin
                if (Ready_SI) state_s = BUSY;
                else          state_s = ISSUE;
            end
            BUSY: begin
                if (Done_SI) state_s = DONE_STATE;
                else         state_s = BUSY;
            end
            RESP: begin
                if (pop_s) state_s = IDLE;
                else       state_s = RESP;
            end
            default: state_s = IDLE;
        endcase
    end

    // Issue register: captured on accept, held until the next accept
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            op_a_r <= '0;
            op_b_r <= '0;
            rm_r   <= '0;
            pc_r   <= '0;
            sqrt_r <= 1'b0;
            tag_r  <= '0;
        end else if (accept_s) begin
            op_a_r <= Operand_a_DI;
            op_b_r <= Operand_b_DI;
            rm_r   <= RM_SI;
            pc_r   <= Precision_ctl_SI;
            sqrt_r <= Sqrt_sel_SI;
            tag_r  <= Tag_DI;
        end else begin
            op_a_r <= op_a_r;
            op_b_r <= op_b_r;
            rm_r   <= rm_r;
            pc_r   <= pc_r;
            sqrt_r <= sqrt_r;
            tag_r  <= tag_r;
        end
    end

    // Sticky flag for a Done arriving when no operation is in flight
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            err_spurious_r <= 1'b0;
        end else if (Done_SI && (state_r != BUSY)) begin
            err_spurious_r <= 1'b1;
        end else begin
            err_spurious_r <= err_spurious_r;
        end
    end

`ifdef DIV_SQRT_RESP_FIFO_EN
    logic [ENTRY_W-1:0] fifo_mem_r [2];
    logic               wr_ptr_r, rd_ptr_r;
    logic [1:0]         count_r;

    // Two-entry response FIFO; head stays put until popped
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            fifo_mem_r[0] <= '0;
            fifo_mem_r[1] <= '0;
            wr_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            count_r       <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= push_entry_s;
                wr_ptr_r             <= ~wr_ptr_r;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) rd_ptr_r <= ~rd_ptr_r;
            else       rd_ptr_r <= rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_entry_s = fifo_mem_r[rd_ptr_r];
    assign buf_valid_s  = (count_r != 2'd0);
    assign buf_free_s   = (count_r <= 2'd1);
`else
    logic [ENTRY_W-1:0] resp_entry_r;
    logic               resp_valid_r;

    // Single response register, filled from BUSY and drained in RESP
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            resp_entry_r <= '0;
            resp_valid_r <= 1'b0;
        end else if (push_s) begin
            resp_entry_r <= push_entry_s;
            resp_valid_r <= 1'b1;
        end else if (pop_s) begin
            resp_entry_r <= resp_entry_r;
            resp_valid_r <= 1'b0;
        end else begin
            resp_entry_r <= resp_entry_r;
            resp_valid_r <= resp_valid_r;
        end
    end

    assign head_entry_s = resp_entry_r;
    assign buf_valid_s  = resp_valid_r;
    assign buf_free_s   = ~resp_valid_r;
`endif

    assign Div_start_SO     = start_s && !sqrt_r;
    assign Sqrt_start_SO    = start_s && sqrt_r;
    assign Operand_a_DO     = op_a_r;
    assign Operand_b_DO     = op_b_r;
    assign RM_SO            = rm_r;
    assign Precision_ctl_SO = pc_r;
    assign Out_valid_SO     = buf_valid_s;
    assign {Result_DO, Flags_DO, Tag_DO} = head_entry_s;
    assign Err_spurious_SO  = err_spurious_r;

endmodule
